// File: rtl/ptr_gen_encode_pkg.sv
// Shared constants for the pointer generator and its Hamming encoder:
// widths, parity-group masks, data-to-code index map and reset codeword.
package ptr_gen_encode_pkg;

  localparam int PTR_DATA_W = 10;
  localparam int PTR_ENC_W  = 14;

  // Each mask lists the data positions that its parity bit covers.
  localparam logic [PTR_ENC_W-1:0] MASK_P0 = 14'h1554; // {2,4,6,8,10,12}
  localparam logic [PTR_ENC_W-1:0] MASK_P1 = 14'h2664; // {2,5,6,9,10,13}
  localparam logic [PTR_ENC_W-1:0] MASK_P3 = 14'h3870; // {4,5,6,11,12,13}
  localparam logic [PTR_ENC_W-1:0] MASK_P7 = 14'h3F00; // {8..13}

  // Element i gives the code index holding data bit d[i].
  localparam logic [PTR_DATA_W-1:0][3:0] DATA_IDX = {
    4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8, 4'd6, 4'd5, 4'd4, 4'd2
  };

  localparam logic [PTR_ENC_W-1:0] ENC_RST = 14'h3F74;

endpackage

// File: rtl/ptr_gen_encode_if.sv
// Handshake bundle for ptr_gen_encode. Error-injection inputs exist only
// when PTR_ERR_INJECT_EN is defined.
interface ptr_gen_encode_if
  import ptr_gen_encode_pkg::*;
  ();

  logic                  inc;
  logic                  clr;
  logic [PTR_DATA_W-1:0] ptr_bin;
  logic                  wrap_flag;
  logic [PTR_ENC_W-1:0]  enc_ptr;
  logic                  enc_upd;
`ifdef PTR_ERR_INJECT_EN
  logic                  inj_req;
  logic [3:0]            inj_idx;
`endif

  modport master (
    output inc, clr,
`ifdef PTR_ERR_INJECT_EN
    output inj_req, inj_idx,
`endif
    input  ptr_bin, wrap_flag, enc_ptr, enc_upd
  );

  modport slave (
    input  inc, clr,
`ifdef PTR_ERR_INJECT_EN
    input  inj_req, inj_idx,
`endif
    output ptr_bin, wrap_flag, enc_ptr, enc_upd
  );

endinterface

// File: rtl/ptr_gen_encode_encode.sv
// Combinational Hamming(14,10) encoder: data bits stored inverted,
// even parity at indices 0, 1, 3, 7 computed over the stored bits.
module ptr_encode
  import ptr_gen_encode_pkg::*;
  (
  input  logic [PTR_DATA_W-1:0] data_i,
  output logic [PTR_ENC_W-1:0]  code_o
);

  logic [PTR_ENC_W-1:0] data_pos;

  always_comb begin
    data_pos = '0;
    for (int i = 0; i < PTR_DATA_W; i++) begin
      data_pos[DATA_IDX[i]] = ~data_i[i];
    end
  end

  always_comb begin
    code_o    = data_pos;
    code_o[0] = ^(data_pos & MASK_P0);
    code_o[1] = ^(data_pos & MASK_P1);
    code_o[3] = ^(data_pos & MASK_P3);
    code_o[7] = ^(data_pos & MASK_P7);
  end

endmodule

// File: rtl/ptr_gen_encode.sv
// Wrapping pointer counter with a registered Hamming-protected copy.
// Optional PTR_ERR_INJECT_EN adds a one-cycle single-bit fault injector.
module ptr_gen_encode
  import ptr_gen_encode_pkg::*;
  #(
  parameter int DEPTH = 1024
) (
  input  logic             clk,
  input  logic             rst,
  ptr_gen_encode_if.slave  bus
);

  localparam int unsigned           LAST_I = DEPTH - 1;
  localparam logic [PTR_DATA_W-1:0] LAST   = LAST_I[PTR_DATA_W-1:0];

  logic [PTR_DATA_W-1:0] ptr_q, ptr_d;
  logic                  wrap_q, wrap_d;
  logic [PTR_ENC_W-1:0]  enc_q, enc_d;
  logic                  upd_q;

  always_comb begin
    ptr_d  = ptr_q;
    wrap_d = wrap_q;
    if (bus.clr) begin
      ptr_d = '0;
    end else if (bus.inc) begin
      if (ptr_q == LAST) begin
        ptr_d  = '0;
        wrap_d = ~wrap_q;
      end else begin
        ptr_d = ptr_q + PTR_DATA_W'(1);
      end
    end
  end

  // Encoding the next-state value keeps enc_q aligned with ptr_q.
  ptr_encode u_encode (
    .data_i (ptr_d),
    .code_o (enc_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      wrap_q <= 1'b0;
      enc_q  <= ENC_RST;
      upd_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      wrap_q <= wrap_d;
      enc_q  <= enc_d;
      upd_q  <= (ptr_d != ptr_q);
    end
  end

`ifdef PTR_ERR_INJECT_EN
  logic [PTR_ENC_W-1:0] inj_mask_q;

  function automatic logic [PTR_ENC_W-1:0] inj_mask(input logic req,
                                                    input logic [3:0] idx);
    logic [PTR_ENC_W-1:0] m;
    m = '0;
    if (req && (idx != 4'd0) && (idx != 4'd15)) begin
      m[idx - 4'd1] = 1'b1;
    end
    return m;
  endfunction

  // The mask lives one cycle only; the clean codeword is never altered.
  always_ff @(posedge clk) begin
    if (rst) begin
      inj_mask_q <= '0;
    end else begin
      inj_mask_q <= inj_mask(bus.inj_req, bus.inj_idx);
    end
  end

  assign bus.enc_ptr = enc_q ^ inj_mask_q;
`else
  assign bus.enc_ptr = enc_q;
`endif

  assign bus.ptr_bin   = ptr_q;
  assign bus.wrap_flag = wrap_q;
  assign bus.enc_upd   = upd_q;

endmodule

// File: tb/tb_ptr_gen_encode.sv
// Directed bench for ptr_gen_encode: vector table plus wrap, clr-priority,
// round-trip decode and (with PTR_ERR_INJECT_EN) injection sequences.
module tb_ptr_gen_encode;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  ptr_gen_encode_if bus ();

  ptr_gen_encode #(.DEPTH(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        clr;
    logic        inc;
    logic [9:0]  ptr;
    logic        wrap;
    logic [13:0] enc;
    logic        upd;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic r, input logic c, input logic i);
    rst     = r;
    bus.clr = c;
    bus.inc = i;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    bus.clr = 1'b0;
    bus.inc = 1'b0;
  endtask

  // Reference Hamming decoder using 1-based positions; parity at 1,2,4,8.
  task automatic decode(input logic [13:0] c, output logic [3:0] syn,
                        output logic [9:0] d);
    logic [13:0] fixed;
    int k;
    syn = '0;
    for (int p = 1; p <= 14; p++) if (c[p-1]) syn ^= 4'(p);
    fixed = c;
    if (syn >= 4'd1 && syn <= 4'd14) fixed[syn-4'd1] = ~fixed[syn-4'd1];
    k = 0;
    d = '0;
    for (int p = 1; p <= 14; p++) begin
      if (p != 1 && p != 2 && p != 4 && p != 8) begin
        d[k] = ~fixed[p-1];
        k++;
      end
    end
  endtask

  logic [3:0] syn;
  logic [9:0] dec;

  initial begin
    rst = 1'b0;
    bus.clr = 1'b0;
    bus.inc = 1'b0;
`ifdef PTR_ERR_INJECT_EN
    bus.inj_req = 1'b0;
    bus.inj_idx = 4'd0;
`endif
    vecs[0] = '{"reset",       1, 0, 0, 10'd0, 0, 14'h3F74, 0};
    vecs[1] = '{"inc1",        0, 0, 1, 10'd1, 0, 14'h3F73, 1};
    vecs[2] = '{"hold1",       0, 0, 0, 10'd1, 0, 14'h3F73, 0};
    vecs[3] = '{"inc2",        0, 0, 1, 10'd2, 0, 14'h3F6D, 1};
    vecs[4] = '{"inc3",        0, 0, 1, 10'd3, 0, 14'h3F6A, 1};
    vecs[5] = '{"clr_at3",     0, 1, 0, 10'd0, 0, 14'h3F74, 1};
    vecs[6] = '{"clr_at0",     0, 1, 0, 10'd0, 0, 14'h3F74, 0};
    vecs[7] = '{"clrinc_at0",  0, 1, 1, 10'd0, 0, 14'h3F74, 0};
    vecs[8] = '{"rst_over_inc",1, 0, 1, 10'd0, 0, 14'h3F74, 0};
    #1;

    for (int v = 0; v < 9; v++) begin
      tick(vecs[v].rst, vecs[v].clr, vecs[v].inc);
      check({vecs[v].name, ".ptr"},  32'(bus.ptr_bin),   32'(vecs[v].ptr));
      check({vecs[v].name, ".wrap"}, 32'(bus.wrap_flag), 32'(vecs[v].wrap));
      check({vecs[v].name, ".enc"},  32'(bus.enc_ptr),   32'(vecs[v].enc));
      check({vecs[v].name, ".upd"},  32'(bus.enc_upd),   32'(vecs[v].upd));
    end

    // Round trip across all 1024 values, ending with a wrap.
    decode(bus.enc_ptr, syn, dec);
    check("rt0.syn", 32'(syn), 32'd0);
    check("rt0.data", 32'(dec), 32'd0);
    for (int n = 1; n < 1024; n++) begin
      tick(1'b0, 1'b0, 1'b1);
      decode(bus.enc_ptr, syn, dec);
      check("cnt.ptr", 32'(bus.ptr_bin), 32'(n));
      check("rt.syn", 32'(syn), 32'd0);
      check("rt.data", 32'(dec), 32'(n));
      check("cnt.upd", 32'(bus.enc_upd), 32'd1);
    end
    check("p1023.enc", 32'(bus.enc_ptr), 32'h0000);
    check("p1023.wrap", 32'(bus.wrap_flag), 32'd0);
    tick(1'b0, 1'b0, 1'b1);
    check("wrap.ptr", 32'(bus.ptr_bin), 32'd0);
    check("wrap.flag", 32'(bus.wrap_flag), 32'd1);
    check("wrap.enc", 32'(bus.enc_ptr), 32'h3F74);
    check("wrap.upd", 32'(bus.enc_upd), 32'd1);

    // clr beats inc at ptr 5; wrap_flag must survive.
    for (int n = 0; n < 5; n++) tick(1'b0, 1'b0, 1'b1);
    check("pre_clr.ptr", 32'(bus.ptr_bin), 32'd5);
    tick(1'b0, 1'b1, 1'b1);
    check("clrpri.ptr", 32'(bus.ptr_bin), 32'd0);
    check("clrpri.wrap", 32'(bus.wrap_flag), 32'd1);
    check("clrpri.enc", 32'(bus.enc_ptr), 32'h3F74);

    // Reset mid-count.
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    check("midrst.ptr", 32'(bus.ptr_bin), 32'd0);
    check("midrst.wrap", 32'(bus.wrap_flag), 32'd0);
    check("midrst.enc", 32'(bus.enc_ptr), 32'h3F74);
    check("midrst.upd", 32'(bus.enc_upd), 32'd0);

`ifdef PTR_ERR_INJECT_EN
    bus.inj_req = 1'b1;
    bus.inj_idx = 4'd3;
    @(posedge clk);
    #1;
    bus.inj_req = 1'b0;
    decode(bus.enc_ptr, syn, dec);
    check("inj.enc", 32'(bus.enc_ptr), 32'h3F70);
    check("inj.syn", 32'(syn), 32'd3);
    check("inj.data", 32'(dec), 32'd0);
    check("inj.ptr", 32'(bus.ptr_bin), 32'd0);
    @(posedge clk);
    #1;
    check("inj.after", 32'(bus.enc_ptr), 32'h3F74);
    for (int k = 0; k < 2; k++) begin
      bus.inj_req = 1'b1;
      bus.inj_idx = (k == 0) ? 4'd0 : 4'd15;
      @(posedge clk);
      #1;
      bus.inj_req = 1'b0;
      check("inj.noflip", 32'(bus.enc_ptr), 32'h3F74);
    end
    bus.inj_req = 1'b1;
    bus.inj_idx = 4'd14;
    tick(1'b0, 1'b0, 1'b1);
    bus.inj_req = 1'b0;
    check("inj14.enc", 32'(bus.enc_ptr), 32'h3F73 ^ 32'h2000);
    check("inj14.ptr", 32'(bus.ptr_bin), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ptr_gen_encode.md
PTR_GEN_ENCODE -- requirements
Module: ptr_gen_encode

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, meaning the pointer range 0..DEPTH-1, legal values 2..1024.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port inc, input, 1 bit: advance the pointer by one this cycle.
REQ-005 The block SHALL have port clr, input, 1 bit: synchronously return the pointer to 0.
REQ-006 The block SHALL have port ptr_bin, output, 10 bits: current binary pointer.
REQ-007 The block SHALL have port wrap_flag, output, 1 bit: toggles on every wrap, for full/empty compare.
REQ-008 The block SHALL have port enc_ptr, output, 14 bits: Hamming-protected encoding of ptr_bin.
REQ-009 The block SHALL have port enc_upd, output, 1 bit: one-cycle pulse in the cycle where enc_ptr first shows a new value.

Function
REQ-010 The counter SHALL change on a clock edge with inc=1: ptr_bin=DEPTH-1 goes to 0 and toggles wrap_flag; any other value increments by 1.
REQ-011 clr=1 SHALL take priority over inc and set ptr_bin=0; wrap_flag SHALL hold its value.
REQ-012 enc_ptr SHALL be a register loaded from the encoding of the next counter value, so enc_ptr always equals encode(ptr_bin) in the same cycle; latency from inc to enc_ptr is one clock.
REQ-013 The encoding code positions SHALL be indices 0..13: parity bits at indices 0, 1, 3, 7; data bits d0..d9 at indices 2, 4, 5, 6, 8, 9, 10, 11, 12, 13, each stored INVERTED (~d).
REQ-014 Parity SHALL be even, computed as the XOR over the stored bits: idx0 covers {2,4,6,8,10,12}; idx1 covers {2,5,6,9,10,13}; idx3 covers {4,5,6,11,12,13}; idx7 covers {8,9,10,11,12,13}.
REQ-015 The XOR-sum of each parity group including its parity bit SHALL equal 0, so the downstream decoder sees syndrome 0.
REQ-016 enc_upd SHALL be 1 exactly in the cycle after an edge where ptr_bin changed; clr at ptr 0, or inc with DEPTH=1 not applicable, SHALL leave it 0.
REQ-017 With DEPTH<1024, unused upper ptr_bin bits SHALL be 0 and SHALL be encoded as 0.

Reset
REQ-018 On rst=1 at an edge, the block SHALL set ptr_bin=0, wrap_flag=0, enc_ptr=14'h3F74 (encode(0)) and enc_upd=0; rst SHALL override clr and inc.
REQ-019 Reset asserted mid-count SHALL take effect at the next edge with no partial update.

Configuration
REQ-020 With macro PTR_ERR_INJECT_EN defined, the block SHALL add inputs inj_req (1 bit) and inj_idx (4 bits); inj_req=1 SHALL flip enc_ptr bit inj_idx-1 for exactly the next cycle only, the counter SHALL be unaffected, and inj_idx of 0 or 15 SHALL cause no flip.
REQ-021 Without PTR_ERR_INJECT_EN, those ports and that logic SHALL be absent, and enc_ptr SHALL always be the clean encoding.

Structure
REQ-022 A shared package SHALL hold PTR_DATA_W=10, PTR_ENC_W=14, the four parity-group index masks, the data-to-code index map, and ENC_RST=14'h3F74.
REQ-023 A combinational sub-module ptr_encode (10-bit input to 14-bit output) SHALL implement REQ-013 to REQ-015, and ptr_gen_encode SHALL instantiate it on the next-state value.

Verification
REQ-024 The bench SHALL cover reset: rst=1 for one cycle, which SHALL produce ptr_bin=0, wrap_flag=0, enc_ptr=14'h3F74, enc_upd=0.
REQ-025 The bench SHALL cover a single increment: one inc pulse after reset, after which ptr_bin=1, enc_ptr=14'h3F73, and enc_upd=1 for one cycle.
REQ-026 The bench SHALL cover wrap: DEPTH=1024, 1024 inc pulses, after which ptr_bin=0 and wrap_flag=1; at ptr 1023, enc_ptr=14'h0000.
REQ-027 The bench SHALL cover clr priority: at ptr_bin=5, drive clr=1 and inc=1 together, after which ptr_bin=0, wrap_flag is unchanged, and enc_ptr=14'h3F74.
REQ-028 The bench SHALL cover a round trip: for all 1024 values, feeding enc_ptr to the team decoder SHALL give syndrome 0 and data equal to ptr_bin.
REQ-029 The bench SHALL cover injection (PTR_ERR_INJECT_EN): at ptr 0, inj_req=1 with inj_idx=3 SHALL give enc_ptr=14'h3F70 for one cycle, decoder syndrome 3 and corrected data 0, then 14'h3F74 the following cycle.
